// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC blocks: FSM state encoding and a width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package crc_pkg;

    // Common state encoding used by the serial CRC back-end stages.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_APPEND = 2'd2
    } crc_state_t;

    // Width of the end-of-data wait counter; covers wait settings 0..15.
    localparam int CRC_WAIT_W = 4;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_shift_out.sv
// Loadable CRC_SIZE-bit shift register emitting one bit per shift, MSB- or LSB-first.
// Latency: head reflects the register contents; load_head is the head of load_val combinationally.
// Backpressure: none; shifts only when told to.
module crc_shift_out #(
    parameter int CRC_SIZE  = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic [CRC_SIZE-1:0] load_val,
    output logic                head,
    output logic                load_head
);

    logic [CRC_SIZE-1:0] sreg;

    // Moves the next bit to emit into the head position.
    function automatic logic [CRC_SIZE-1:0] advance(input logic [CRC_SIZE-1:0] v);
        if (MSB_FIRST) begin
            return v << 1;
        end
        return v >> 1;
    endfunction

    // Head taps for the stored word and for a word about to be loaded.
    always_comb begin
        head      = MSB_FIRST ? sreg[CRC_SIZE-1] : sreg[0];
        load_head = MSB_FIRST ? load_val[CRC_SIZE-1] : load_val[0];
    end

    // Load (optionally consuming the first bit in the same cycle) or shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= shift ? advance(load_val) : load_val;
        end else if (shift) begin
            sreg <= advance(sreg);
        end
    end

endmodule

// File: rtl/crc_append_serializer.sv
// Passes a bit-serial frame through and appends the sampled CRC word on the same line.
// Latency: 1 cycle pass-through; CRC follows the last data bit after CRC_WAIT idle cycles.
// Backpressure: none; enable while busy is dropped and flagged with a one-cycle overrun pulse.
module crc_append_serializer
    import crc_pkg::*;
#(
    parameter int CRC_SIZE  = 32,   // must be at least 2
    parameter bit MSB_FIRST = 1'b1,
    parameter int CRC_WAIT  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial,
    input  logic                enable,
    input  logic [CRC_SIZE-1:0] crc_in,
    output logic                data_out,
    output logic                out_valid,
    output logic                crc_phase,
    output logic                done,
    output logic                overrun
);

    localparam int CNT_W = (clog2(CRC_SIZE) < 1) ? 1 : clog2(CRC_SIZE);
    // The sampling edge already emits the first CRC bit, so APPEND covers the remaining CRC_SIZE-1.
    localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(CRC_SIZE - 2);
    localparam logic [CRC_WAIT_W-1:0] WAIT_LOAD = CRC_WAIT_W'((CRC_WAIT > 0) ? CRC_WAIT - 1 : 0);

    crc_state_t            state, state_nxt;
    logic                  en_q, en_q_nxt;
    logic [CRC_WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0]      bit_cnt, cnt_nxt;
    logic                  data_nxt, valid_nxt, phase_nxt, done_nxt, ovr_nxt;
    logic                  start_crc;
    logic                  sh_load, sh_shift, sh_head, sh_load_head;

    crc_shift_out #(
        .CRC_SIZE  (CRC_SIZE),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .shift     (sh_shift),
        .load_val  (crc_in),
        .head      (sh_head),
        .load_head (sh_load_head)
    );

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        en_q_nxt  = 1'b0;
        wait_nxt  = wait_cnt;
        cnt_nxt   = bit_cnt;
        data_nxt  = 1'b0;
        valid_nxt = 1'b0;
        phase_nxt = 1'b0;
        done_nxt  = 1'b0;
        ovr_nxt   = 1'b0;
        start_crc = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;

        case (state)
            ST_IDLE: begin
                // en_q only tracks accepted bits, so a dropped overrun bit never fakes a frame end.
                en_q_nxt  = enable;
                data_nxt  = serial;
                valid_nxt = enable;
                if (!enable && en_q) begin
                    if (CRC_WAIT == 0) begin
                        start_crc = 1'b1;
                    end else begin
                        wait_nxt  = WAIT_LOAD;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                ovr_nxt = enable;
                if (wait_cnt == '0) begin
                    start_crc = 1'b1;
                end else begin
                    wait_nxt = wait_cnt - 1'b1;
                end
            end
            ST_APPEND: begin
                ovr_nxt   = enable;
                data_nxt  = sh_head;
                valid_nxt = 1'b1;
                phase_nxt = 1'b1;
                sh_shift  = 1'b1;
                if (bit_cnt == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = bit_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Sample crc_in and emit its first bit on the same edge so data and CRC stay contiguous.
        if (start_crc) begin
            sh_load   = 1'b1;
            sh_shift  = 1'b1;
            data_nxt  = sh_load_head;
            valid_nxt = 1'b1;
            phase_nxt = 1'b1;
            cnt_nxt   = CNT_LOAD;
            state_nxt = ST_APPEND;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            en_q      <= 1'b0;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
            data_out  <= 1'b0;
            out_valid <= 1'b0;
            crc_phase <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            en_q      <= en_q_nxt;
            wait_cnt  <= wait_nxt;
            bit_cnt   <= cnt_nxt;
            data_out  <= data_nxt;
            out_valid <= valid_nxt;
            crc_phase <= phase_nxt;
            done      <= done_nxt;
            overrun   <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_crc_append_serializer.sv
// Self-checking bench: three configurations driven by shared stimulus, compared per cycle to a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_crc_append_serializer;

    localparam int MAXC = 640;

    logic        clk = 1'b0;
    logic        rst, serial, enable;
    logic [31:0] crc_bus;

    logic a_d, a_v, a_p, a_done, a_o;
    logic b_d, b_v, b_p, b_done, b_o;
    logic c_d, c_v, c_p, c_done, c_o;

    always #5 clk = ~clk;

    crc_append_serializer #(.CRC_SIZE(32), .MSB_FIRST(1'b1), .CRC_WAIT(0)) dut_a (
        .clk(clk), .rst(rst), .serial(serial), .enable(enable), .crc_in(crc_bus),
        .data_out(a_d), .out_valid(a_v), .crc_phase(a_p), .done(a_done), .overrun(a_o));

    crc_append_serializer #(.CRC_SIZE(32), .MSB_FIRST(1'b1), .CRC_WAIT(3)) dut_b (
        .clk(clk), .rst(rst), .serial(serial), .enable(enable), .crc_in(crc_bus),
        .data_out(b_d), .out_valid(b_v), .crc_phase(b_p), .done(b_done), .overrun(b_o));

    crc_append_serializer #(.CRC_SIZE(8), .MSB_FIRST(1'b0), .CRC_WAIT(0)) dut_c (
        .clk(clk), .rst(rst), .serial(serial), .enable(enable), .crc_in(crc_bus[7:0]),
        .data_out(c_d), .out_valid(c_v), .crc_phase(c_p), .done(c_done), .overrun(c_o));

    // Per-cycle stimulus of the current scenario.
    logic        en_s  [MAXC];
    logic        ser_s [MAXC];
    logic        rst_s [MAXC];
    logic [31:0] crc_s [MAXC];
    int          slen;

    // Observed {valid, data, crc_phase, done, overrun} per DUT per cycle.
    logic [4:0]  obs [3][MAXC];

    // Expected outputs per cycle; edc marks cycles where data_out is defined.
    logic ev [MAXC+1];
    logic ed [MAXC+1];
    logic edc[MAXC+1];
    logic ep [MAXC+1];
    logic edn[MAXC+1];
    logic eo [MAXC+1];

    int checks = 0;
    int errors = 0;

    task automatic add(input logic e, input logic s, input logic r, input logic [31:0] cr);
        if (slen < MAXC) begin
            en_s[slen]  = e;
            ser_s[slen] = s;
            rst_s[slen] = r;
            crc_s[slen] = cr;
            slen++;
        end
    endtask

    task automatic add_idle(input int n, input logic [31:0] cr);
        for (int i = 0; i < n; i++) add(1'b0, 1'($urandom), 1'b0, cr);
    endtask

    // Frame bits are sent from bits[n-1] down to bits[0].
    task automatic add_frame(input int n, input logic [127:0] bits, input logic [31:0] cr);
        for (int i = n - 1; i >= 0; i--) add(1'b1, bits[i], 1'b0, cr);
    endtask

    task automatic clear_exp(input int k);
        ev[k] = 1'b0; ed[k] = 1'b0; edc[k] = 1'b0; ep[k] = 1'b0; edn[k] = 1'b0; eo[k] = 1'b0;
    endtask

    // Frame-level reference: data bits echo one cycle late; after the last data cycle T the
    // CRC (value present in cycle T+1+w) occupies cycles T+2+w .. T+1+w+n with done on the last;
    // enable during cycles T+2 .. T+w+n is an overrun flagged in the following cycle.
    task automatic model(input int n, input int w, input bit msb);
        int  bs, be, t, smp, idx;
        bit  open;
        logic [31:0] cv;
        for (int k = 0; k <= MAXC; k++) clear_exp(k);
        open = 1'b0;
        bs = -1;
        be = -2;
        for (int c = 0; c < slen; c++) begin
            if (rst_s[c]) begin
                for (int k = c + 1; k <= MAXC; k++) clear_exp(k);
                edc[c+1] = 1'b1;
                open = 1'b0;
                bs = -1;
                be = -2;
            end else if (c >= bs && c <= be) begin
                if (en_s[c]) eo[c+1] = 1'b1;
            end else if (en_s[c]) begin
                ev[c+1]  = 1'b1;
                ed[c+1]  = ser_s[c];
                edc[c+1] = 1'b1;
                open = 1'b1;
            end else if (open) begin
                open = 1'b0;
                t   = c - 1;
                smp = t + 1 + w;
                cv  = crc_s[(smp < slen) ? smp : slen - 1];
                for (int j = 0; j < n; j++) begin
                    idx = t + 2 + w + j;
                    if (idx <= MAXC) begin
                        ev[idx]  = 1'b1;
                        ed[idx]  = msb ? cv[n-1-j] : cv[j];
                        edc[idx] = 1'b1;
                        ep[idx]  = 1'b1;
                        edn[idx] = (j == n - 1);
                    end
                end
                bs = t + 2;
                be = t + w + n;
            end
        end
    endtask

    // Apply the scenario, record all outputs, then check each DUT against the model.
    task automatic run(input string name);
        logic [4:0] got, want;
        for (int c = 0; c < slen; c++) begin
            @(posedge clk);
            #1;
            rst     = rst_s[c];
            enable  = en_s[c];
            serial  = ser_s[c];
            crc_bus = crc_s[c];
            @(negedge clk);
            obs[0][c] = {a_v, a_d, a_p, a_done, a_o};
            obs[1][c] = {b_v, b_d, b_p, b_done, b_o};
            obs[2][c] = {c_v, c_d, c_p, c_done, c_o};
        end
        for (int d = 0; d < 3; d++) begin
            if (d == 0)      model(32, 0, 1'b1);
            else if (d == 1) model(32, 3, 1'b1);
            else             model(8, 0, 1'b0);
            for (int c = 0; c < slen; c++) begin
                got  = {obs[d][c][4], obs[d][c][3] & edc[c], obs[d][c][2:0]};
                want = {ev[c], ed[c], ep[c], edn[c], eo[c]};
                checks++;
                assert (got === want) else begin
                    errors++;
                    $error("FAIL %s dut%0d cyc%0d {v,d,ph,done,ovr} got %b want %b", name, d, c, got, want);
                end
            end
        end
        slen = 0;
    endtask

    initial begin
        int t;
        int gap, flen;
        logic [127:0] rb;

        rst = 1'b1; enable = 1'b0; serial = 1'b0; crc_bus = '0;
        slen = 0;
        repeat (2) @(posedge clk);

        // Reset state, then the reference 128-bit frame; crc_in cleared after every DUT sampled it.
        add(1'b0, 1'b0, 1'b1, 32'h0);
        add(1'b0, 1'b1, 1'b1, 32'h0);
        add(1'b0, 1'b0, 1'b1, 32'h0);
        add_idle(2, 32'hDEADBEEF);
        add_frame(128, 128'h73713cb13141af131d313d3231398810, 32'hDEADBEEF);
        t = slen - 1;
        add_idle(70, 32'hDEADBEEF);
        for (int k = t + 6; k < slen; k++) crc_s[k] = 32'h0;
        run("frame128");

        // Single-bit frame; the 8-bit LSB-first DUT sees 0xA5.
        add_idle(3, 32'hDEADBEA5);
        add_frame(1, 128'h1, 32'hDEADBEA5);
        t = slen - 1;
        add_idle(60, 32'hDEADBEA5);
        for (int k = t + 6; k < slen; k++) crc_s[k] = 32'h0;
        run("onebit");

        // Overrun pulse during APPEND, then a frame rising in the 32-bit WAIT=0 DUT's done cycle.
        add_idle(3, 32'h1234_5678);
        rb = {$urandom, $urandom, $urandom, $urandom};
        add_frame(8, rb, 32'h1234_5678);
        t = slen - 1;
        add_idle(110, 32'h1234_5678);
        en_s[t+5] = 1'b1;
        for (int k = t + 33; k <= t + 36; k++) en_s[k] = 1'b1;
        run("overrun_b2b");

        // Frame starting one cycle before done is partly an overrun.
        add_idle(3, 32'hCAFE_F00D);
        rb = {$urandom, $urandom, $urandom, $urandom};
        add_frame(6, rb, 32'hCAFE_F00D);
        t = slen - 1;
        add_idle(110, 32'hCAFE_F00D);
        for (int k = t + 32; k <= t + 36; k++) en_s[k] = 1'b1;
        run("early_start");

        // Reset on the 10th CRC bit, then a 16-bit frame.
        add_idle(3, 32'h0F0F_3C3C);
        rb = {$urandom, $urandom, $urandom, $urandom};
        add_frame(20, rb, 32'h0F0F_3C3C);
        t = slen - 1;
        add_idle(30, 32'h0F0F_3C3C);
        rst_s[t+11] = 1'b1;
        rb = {$urandom, $urandom, $urandom, $urandom};
        add_frame(16, rb, 32'h89AB_CDEF);
        add_idle(60, 32'h89AB_CDEF);
        run("reset_mid");

        // Long quiet period.
        add_idle(100, $urandom);
        run("idle100");

        // Random frames and gaps with crc_in changing every cycle.
        for (int r = 0; r < 4; r++) begin
            while (slen < 420) begin
                gap = $urandom_range(0, 40);
                for (int i = 0; i < gap; i++) add(1'b0, 1'($urandom), 1'b0, $urandom);
                flen = $urandom_range(1, 40);
                for (int i = 0; i < flen; i++) add(1'b1, 1'($urandom), 1'b0, $urandom);
            end
            for (int i = 0; i < 60; i++) add(1'b0, 1'($urandom), 1'b0, $urandom);
            run("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
